// File: rtl/iter_div.sv
// Iterative radix-2 restoring divider: signed/unsigned quotient and remainder,
// WIDTH+1 cycle latency, valid/ready on both sides, tag carried through.
module iter_div #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dbz;
  logic [TAG_W-1:0] r_tag;

  logic             w_acc;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;

  assign in_ready  = !flush && ((r_state == S_IDLE) || (r_state == S_DONE && out_ready));
  assign w_acc     = in_valid && in_ready;
  // MIN negates to itself, which read unsigned is exactly 2^(WIDTH-1)
  assign w_dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_dvs_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  // r_q shifts dividend bits out of the top while quotient bits enter the bottom.
  // Partial remainder stays below the divisor, so the WIDTH+1-bit trial
  // difference never overflows and its MSB is the borrow.
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_qbit  = ~w_diff[WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_dbz   <= 1'b0;
      r_tag   <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else if (w_acc) begin
      r_tag   <= in_tag;
      r_dvs   <= w_dvs_mag;
      r_q_neg <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_r_neg <= is_signed && dividend[WIDTH-1];
      r_cnt   <= '0;
      if (divisor == '0) begin
        r_dbz   <= 1'b1;
        r_q     <= '1;
        r_rem   <= dividend;
        r_state <= S_DONE;
      end else begin
        r_dbz   <= 1'b0;
        r_q     <= w_dvd_mag;
        r_rem   <= '0;
        r_state <= S_CALC;
      end
    end else begin
      case (r_state)
        S_CALC: begin
          r_rem <= w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_q_neg) r_q   <= -r_q;
          if (r_r_neg) r_rem <= -r_rem;
          r_state <= S_DONE;
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: ;
      endcase
    end
  end

  assign out_valid   = (r_state == S_DONE);
  assign quotient    = r_q;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
  assign out_tag     = r_tag;

endmodule

// File: tb/tb_iter_div.sv
// Scoreboard bench for iter_div: directed corners, back-pressure, flush,
// async reset, then a randomized run checked against plain-arithmetic division.
module tb_iter_div;
  localparam int W  = 32;
  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          is_signed = 1'b0;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          div_by_zero;
  logic [TW-1:0] out_tag;

  iter_div #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic          dbz;
    logic [TW-1:0] tag;
    int            cyc;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   seen  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: truncating division on 64-bit integers; MIN/-1 wraps naturally.
  task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r);
    longint na, nb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      if (s) begin
        na = longint'($signed(a));
        nb = longint'($signed(b));
      end else begin
        na = longint'({32'b0, a});
        nb = longint'({32'b0, b});
      end
      q = W'(na / nb);
      r = W'(na % nb);
    end
  endtask

  // One clock: drive at negedge+2, sample handshake, commit scoreboard at posedge.
  task automatic step(input logic iv, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] tg, input logic ordy, input logic fl,
                      output logic acc, output logic rdy);
    logic hs;
    exp_t e;
    @(negedge clk);
    #2;
    in_valid = iv; is_signed = s; dividend = a; divisor = b; in_tag = tg;
    out_ready = ordy; flush = fl;
    #1;
    rdy = in_ready;
    acc = iv && in_ready;
    hs  = out_valid && ordy && !fl;
    @(posedge clk);
    cyc++;
    if (fl) begin
      sb.delete();
      seen = 1'b0;
    end else begin
      if (hs) seen = 1'b0;
      if (acc) begin
        model(s, a, b, e.q, e.r);
        e.dbz = (b == '0);
        e.tag = tg;
        e.cyc = cyc;
        e.lat = (b == '0) ? 0 : W + 1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic ordy);
    logic acc, rdy;
    step(1'b0, 1'b0, '0, '0, '0, ordy, 1'b0, acc, rdy);
  endtask

  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tg);
    logic acc, rdy;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) step(1'b1, s, a, b, tg, 1'b1, 1'b0, acc, rdy);
    check("issue_accept", acc, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || seen) && n < 200) begin
      idle(1'b1);
      n++;
    end
    check("drain_timeout", (n >= 200), 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && !seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        check("unexpected_out_valid", out_tag, '1);
        tests++; fails++;
        $display("FAIL unexpected result: tag %0h q %0h with nothing pending", out_tag, quotient);
      end else begin
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.dbz);
        check("out_tag", out_tag, e.tag);
        check("latency", cyc - e.cyc, e.lat);
      end
    end
  end

  function automatic logic [W-1:0] rnd_op(input bit is_div);
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = is_div ? '0 : 32'h8000_0000;
      1: v = '1;
      2: v = 32'd1;
      3: v = W'($urandom_range(0, 15));
      4: v = W'(-int'($urandom_range(1, 15)));
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc, rdy;
    logic [W-1:0] sq, sr;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_quotient", quotient, '0);
    check("reset_remainder", remainder, '0);
    check("reset_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    issue(1'b0, 32'd100, 32'd7, 6'd5); drain();
    issue(1'b1, W'(-7), 32'd2, 6'd1); drain();
    issue(1'b1, 32'd7, W'(-2), 6'd2); drain();
    issue(1'b1, W'(-7), W'(-2), 6'd3); drain();
    issue(1'b0, 32'hFFFF_FFF9, 32'd2, 6'd4); drain();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd6); drain();
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 6'd7); drain();
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 6'd8); drain();
    issue(1'b0, 32'd5, 32'd0, 6'd9); drain();
    issue(1'b1, 32'h8000_0000, 32'd3, 6'd10); drain();

    // Back-pressure then same-cycle consume + accept.
    issue(1'b0, 32'd20, 32'd3, 6'd11);
    for (int i = 0; i < 60 && !seen; i++) idle(1'b0);
    #1;
    sq = quotient; sr = remainder;
    check("bp_reached_done", out_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, acc, rdy);
      check("bp_in_ready", rdy, 1'b0);
      #1;
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_q_stable", quotient, sq);
      check("bp_r_stable", remainder, sr);
    end
    step(1'b1, 1'b0, 32'd9, 32'd3, 6'd12, 1'b1, 1'b0, acc, rdy);
    check("b2b_accept", acc, 1'b1);
    drain();

    // Flush mid-CALC: op dropped, next op accepted right after.
    issue(1'b0, 32'd1234, 32'd7, 6'd13);
    repeat (9) idle(1'b1);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, acc, rdy);
    step(1'b1, 1'b0, 32'd50, 32'd5, 6'd14, 1'b1, 1'b0, acc, rdy);
    check("flush_in_ready", rdy, 1'b1);
    check("flush_next_accept", acc, 1'b1);
    drain();

    // Async reset mid-CALC, between clock edges.
    issue(1'b1, W'(-1000), 32'd3, 6'd15);
    repeat (10) idle(1'b1);
    #3;
    reset = 1'b1;
    #1;
    check("areset_out_valid", out_valid, 1'b0);
    check("areset_quotient", quotient, '0);
    check("areset_remainder", remainder, '0);
    check("areset_dbz", div_by_zero, 1'b0);
    check("areset_tag", out_tag, '0);
    sb.delete();
    seen = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    idle(1'b1);
    #1;
    check("post_reset_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 20000; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), rnd_op(1'b0), rnd_op(1'b1),
           TW'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, acc, rdy);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
